// File: rtl/tff_pkg.sv
// Shared constants and the next-state helper for the toggle flip-flop register.
package tff_pkg;

    localparam int   TFF_DEFAULT_WIDTH = 1;
    localparam logic TFF_RESET_VAL     = 1'b0;
    localparam logic TFF_PRESET_VAL    = 1'b1;
    localparam logic ACTIVE_LOW        = 1'b0;

    // A bit flips only when both the enable and its toggle request are high.
    function automatic logic tff_next(input logic q, input logic t, input logic ce);
        return q ^ (t & ce);
    endfunction

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop cell: asynchronous clear over preset, then the clocked toggle.
module tff_bit
    import tff_pkg::*;
(
    output logic q,
    input  logic t,
    input  logic ce,
    input  logic clk,
    input  logic preset,
    input  logic clear
);

    // Clear wins when both asynchronous pins are low, so a cell with both tied low stays at 0.
    always_ff @(posedge clk or negedge clear or negedge preset) begin
        if (clear == ACTIVE_LOW)
            q <= TFF_RESET_VAL;
        else if (preset == ACTIVE_LOW)
            q <= TFF_PRESET_VAL;
        else
            q <= tff_next(q, t, ce);
    end

endmodule

// File: rtl/tff.sv
// WIDTH-bit toggle register with true/complement outputs and async active-low preset/clear.
// Optional clock enable port ce is added when TFF_CE_EN is defined.
module tff
    import tff_pkg::*;
#(
    parameter int WIDTH = TFF_DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             preset,
    input  logic             clear
`ifdef TFF_CE_EN
    ,
    input  logic             ce
`endif
);

    logic ce_eff;

`ifdef TFF_CE_EN
    assign ce_eff = ce;
`else
    assign ce_eff = 1'b1;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit u_bit (
            .q      (q[i]),
            .t      (t[i]),
            .ce     (ce_eff),
            .clk    (clk),
            .preset (preset),
            .clear  (clear)
        );
    end

    // Complement is derived combinationally so it tracks q through preset and clear.
    assign qnot = ~q;

endmodule

// File: tb/tb_tff.sv
// Directed testbench for tff: a 1-bit and a 4-bit instance sharing clock, preset and clear.
module tb_tff;

    logic       clk;
    logic       preset;
    logic       clear;
    logic       ce;
    logic       t1;
    logic [3:0] t4;
    logic       q1, qn1;
    logic [3:0] q4, qn4;

    int errors = 0;
    int checks = 0;

    tff #(.WIDTH(1)) dut1 (
        .q      (q1),
        .qnot   (qn1),
        .t      (t1),
        .clk    (clk),
        .preset (preset),
        .clear  (clear)
`ifdef TFF_CE_EN
        ,
        .ce     (ce)
`endif
    );

    tff #(.WIDTH(4)) dut4 (
        .q      (q4),
        .qnot   (qn4),
        .t      (t4),
        .clk    (clk),
        .preset (preset),
        .clear  (clear)
`ifdef TFF_CE_EN
        ,
        .ce     (ce)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear = 1'b0; preset = 1'b1; t1 = 1'b1; t4 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (q1 !== 1'b0 || qn1 !== 1'b1) begin
                errors++;
                $display("FAIL reset_w1 cyc%0d: q=%b qnot=%b, required q=0 qnot=1", i, q1, qn1);
            end
            checks++;
            if (q4 !== 4'b0000 || qn4 !== 4'b1111) begin
                errors++;
                $display("FAIL reset_w4 cyc%0d: q=%b qnot=%b, required q=0000 qnot=1111", i, q4, qn4);
            end
        end
    endtask

    task automatic test_both_low();
        clear = 1'b0; preset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v  = 4'(i);
            t1 = v[0];
            t4 = v;
            step();
            checks++;
            if (q1 !== 1'b0 || q4 !== 4'b0000) begin
                errors++;
                $display("FAIL both_low t=%b: q1=%b q4=%b, required 0 and 0000", v, q1, q4);
            end
        end
        preset = 1'b1;
    endtask

    task automatic test_toggle();
        logic exp;
        t1 = 1'b1; t4 = 4'b0000;
        clear = 1'b1; preset = 1'b1;
        exp = 1'b0;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL release_hold: q=%b, required 0", q1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            exp = ~exp;
            checks++;
            if (q1 !== exp || qn1 !== ~exp) begin
                errors++;
                $display("FAIL toggle edge%0d: q=%b qnot=%b, required q=%b qnot=%b", i, q1, qn1, exp, ~exp);
            end
        end
    endtask

    task automatic test_hold_clear();
        t1 = 1'b1;
        step();
        t1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q1 !== 1'b1) begin
                errors++;
                $display("FAIL hold edge%0d: q=%b, required 1", i, q1);
            end
        end
        #2 clear = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            errors++;
            $display("FAIL async_clear: q=%b qnot=%b, required q=0 qnot=1", q1, qn1);
        end
        @(negedge clk);
        clear = 1'b1;
    endtask

    task automatic test_preset();
        t1 = 1'b0; t4 = 4'b0000;
        #2 preset = 1'b0;
        #1;
        checks++;
        if (q1 !== 1'b1 || qn1 !== 1'b0 || q4 !== 4'b1111) begin
            errors++;
            $display("FAIL async_preset: q1=%b qnot=%b q4=%b, required 1 0 1111", q1, qn1, q4);
        end
        t1 = 1'b1;
        @(posedge clk);
        #1 preset = 1'b1;
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL preset_release_edge: q=%b, required 1", q1);
        end
        @(negedge clk);
        step();
        checks++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            errors++;
            $display("FAIL first_toggle_after_preset: q=%b qnot=%b, required 0 1", q1, qn1);
        end
        t1 = 1'b0;
    endtask

    task automatic test_width4();
        #2 clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        t4 = 4'b1010;
        step();
        checks++;
        if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
            errors++;
            $display("FAIL w4_toggle: q=%b qnot=%b, required 1010 0101", q4, qn4);
        end
`ifdef TFF_CE_EN
        ce = 1'b0; t4 = 4'b1111;
        step();
        checks++;
        if (q4 !== 4'b1010) begin
            errors++;
            $display("FAIL w4_ce_hold: q=%b, required 1010", q4);
        end
        ce = 1'b1;
`endif
        t4 = 4'b0000;
        step();
        checks++;
        if (q4 !== 4'b1010) begin
            errors++;
            $display("FAIL w4_t0_hold: q=%b, required 1010", q4);
        end
        t4 = 4'b0101;
        step();
        checks++;
        if (q4 !== 4'b1111 || qn4 !== 4'b0000) begin
            errors++;
            $display("FAIL w4_second: q=%b qnot=%b, required 1111 0000", q4, qn4);
        end
        t4 = 4'b0110;
        step();
        checks++;
        if (q4 !== 4'b1001) begin
            errors++;
            $display("FAIL w4_mixed: q=%b, required 1001", q4);
        end
    endtask

    initial begin
        clear = 1'b0; preset = 1'b1; ce = 1'b1; t1 = 1'b0; t4 = 4'b0000;
        @(negedge clk);
        test_reset();
        test_both_low();
        test_toggle();
        test_hold_clear();
        test_preset();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
